// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (signed/unsigned) with start/busy/done handshake.
// One trial subtraction per clock over WIDTH iterations, then a sign-fix cycle.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             Zf,
  output logic             Of,
  output logic             Sf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             signed_r;
  logic             sign_q_r;
  logic             sign_rem_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] bmag_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH:0]   rem_sh_s;
  logic             borrow_s;
  logic [WIDTH-1:0] trial_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic             of_s;

  // Operand magnitudes, one trial subtraction, and the final sign fix-up.
  always_comb begin
    a_mag_s    = (is_signed && a[WIDTH-1]) ? (ZERO - a) : a;
    b_mag_s    = (is_signed && b[WIDTH-1]) ? (ZERO - b) : b;
    rem_sh_s   = {rem_r, q_r[WIDTH-1]};
    // The WIDTH+1-bit shifted remainder borrows exactly when it is below the divisor.
    borrow_s   = (rem_sh_s < {1'b0, bmag_r});
    trial_s    = rem_sh_s[WIDTH-1:0] - bmag_r;
    quot_fix_s = sign_q_r ? (ZERO - q_r) : q_r;
    rem_fix_s  = sign_rem_r ? (ZERO - rem_r) : rem_r;
    of_s       = signed_r && (a_r == MIN_NEG) && (b_r == ALL_ONES);
  end

  // Control FSM, iteration datapath and registered result/flag outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      a_r        <= ZERO;
      b_r        <= ZERO;
      signed_r   <= 1'b0;
      sign_q_r   <= 1'b0;
      sign_rem_r <= 1'b0;
      rem_r      <= ZERO;
      q_r        <= ZERO;
      bmag_r     <= ZERO;
      cnt_r      <= {CW{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      quotient   <= ZERO;
      remainder  <= ZERO;
      Zf         <= 1'b0;
      Of         <= 1'b0;
      Sf         <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            signed_r <= is_signed;
            if (b == ZERO) begin
              state_r   <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= ALL_ONES;
              remainder <= a;
              Zf        <= 1'b1;
              Of        <= 1'b0;
              Sf        <= 1'b1;
            end else begin
              state_r    <= CALC;
              busy       <= 1'b1;
              done       <= 1'b0;
              Zf         <= 1'b0;
              Of         <= 1'b0;
              sign_q_r   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              sign_rem_r <= is_signed & a[WIDTH-1];
              rem_r      <= ZERO;
              q_r        <= a_mag_s;
              bmag_r     <= b_mag_s;
              cnt_r      <= {CW{1'b0}};
            end
          end else begin
            state_r <= IDLE;
            done    <= 1'b0;
          end
        end
        CALC: begin
          q_r   <= {q_r[WIDTH-2:0], ~borrow_s};
          rem_r <= borrow_s ? rem_sh_s[WIDTH-1:0] : trial_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          quotient  <= quot_fix_s;
          remainder <= rem_fix_s;
          Sf        <= quot_fix_s[WIDTH-1];
          Of        <= of_s;
          busy      <= 1'b0;
          done      <= 1'b1;
          state_r   <= DONE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, Zf, Of, Sf;
  logic [31:0] quotient, remainder;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .Zf(Zf), .Of(Of), .Sf(Sf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Truncating division from plain integer arithmetic (64-bit avoids min/-1 overflow).
  function automatic logic [31:0] ref_q(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (y == 32'd0) return 32'hFFFF_FFFF;
    if (s) return 32'(sx / sy);
    return x / y;
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (y == 32'd0) return x;
    if (s) return 32'(sx % sy);
    return x % y;
  endfunction

  // Protocol-level model: what the outputs must be after each edge.
  int          m_left;
  logic        m_busy, m_done, m_zf, m_of, m_sf;
  logic [31:0] m_q, m_r, p_q, p_r;
  logic        p_of;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_q <= 32'd0; m_r <= 32'd0; m_zf <= 1'b0; m_of <= 1'b0; m_sf <= 1'b0;
      p_q <= 32'd0; p_r <= 32'd0; p_of <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_q <= p_q; m_r <= p_r; m_sf <= p_q[31]; m_of <= p_of;
      end
    end else if (start) begin
      if (b == 32'd0) begin
        m_done <= 1'b1; m_q <= 32'hFFFF_FFFF; m_r <= a;
        m_zf <= 1'b1; m_of <= 1'b0; m_sf <= 1'b1;
      end else begin
        m_left <= 33; m_busy <= 1'b1; m_done <= 1'b0;
        m_zf <= 1'b0; m_of <= 1'b0;
        p_q <= ref_q(a, b, is_signed);
        p_r <= ref_r(a, b, is_signed);
        p_of <= is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("flags", {29'd0, Zf, Of, Sf}, {29'd0, m_zf, m_of, m_sf});
    end
  end

  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic s);
    @(negedge clk);
    a = av; b = bv; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the negedge after the accepting edge; returns at the done cycle.
  task automatic wait_done(output int n, output int bc);
    n = 1; bc = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_res(input string name, input logic [31:0] q, input logic [31:0] r,
                            input logic [2:0] zos);
    chk({name, "_q"}, quotient, q);
    chk({name, "_r"}, remainder, r);
    chk({name, "_zos"}, {29'd0, Zf, Of, Sf}, {29'd0, zos});
  endtask

  function automatic logic [31:0] rand_b();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'($urandom_range(1, 15));
      2: return 32'hFFFF_FFFF;
      3: return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, bc;
    // Model sanity on hand-computed values.
    chk("ref_q_100_7", ref_q(32'd100, 32'd7, 1'b0), 32'd14);
    chk("ref_r_100_7", ref_r(32'd100, 32'd7, 1'b0), 32'd2);
    chk("ref_q_m7_2s", ref_q(32'hFFFF_FFF9, 32'd2, 1'b1), 32'hFFFF_FFFD);
    chk("ref_r_m7_2s", ref_r(32'hFFFF_FFF9, 32'd2, 1'b1), 32'hFFFF_FFFF);
    chk("ref_q_min_m1", ref_q(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), 32'h8000_0000);

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    expect_res("reset", 32'd0, 32'd0, 3'b000);
    rst = 1'b0;

    launch(32'd100, 32'd7, 1'b0);
    wait_done(n, bc);
    chk("lat_busy_cycles", 32'(bc), 32'd33);
    chk("lat_done_cycle", 32'(n), 32'd34);
    expect_res("u100_7", 32'd14, 32'd2, 3'b000);

    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(n, bc);
    expect_res("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 3'b001);
    launch(32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done(n, bc);
    expect_res("u_m7_2", 32'h7FFF_FFFC, 32'd1, 3'b000);

    launch(32'h0000_1234, 32'd0, 1'b1);
    wait_done(n, bc);
    chk("zdiv_done_cycle", 32'(n), 32'd1);
    chk("zdiv_busy_cycles", 32'(bc), 32'd0);
    expect_res("zdiv", 32'hFFFF_FFFF, 32'h0000_1234, 3'b101);

    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(n, bc);
    expect_res("s_ovf", 32'h8000_0000, 32'd0, 3'b011);
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done(n, bc);
    expect_res("u_ovf", 32'd0, 32'h8000_0000, 3'b000);

    // Start pulsed mid-calculation is ignored; then back-to-back accept from DONE.
    launch(32'd100, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    a = 32'd9; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bc);
    expect_res("ignore_busy", 32'd14, 32'd2, 3'b000);
    a = 32'd9; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bc);
    chk("b2b_done_cycle", 32'(n), 32'd34);
    expect_res("b2b", 32'd3, 32'd0, 3'b000);

    // Asynchronous reset mid-operation.
    launch(32'hFFFF_FFFF, 32'd1, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    expect_res("arst", 32'd0, 32'd0, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    launch(32'd50, 32'd5, 1'b0);
    wait_done(n, bc);
    chk("post_rst_lat", 32'(n), 32'd34);
    expect_res("post_rst", 32'd10, 32'd0, 3'b000);

    // Random traffic: sporadic starts (often while busy) and rare resets.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 999) == 0);
      start = ($urandom_range(0, 3) == 0);
      is_signed = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      end else begin
        a = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 3) == 0) a = ~a;
        b = rand_b();
      end
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
